multi_compuerta: RTL and testbench
==================================

MULTI_COMPUERTA -- requirements
Module: multi_compuerta

Interface
Parameters:
REQ-001 The block SHALL have parameter RESET_F, default 1'b0, giving the value loaded into F on reset.
REQ-002 The block SHALL have parameter DEFAULT_SEL, default 3'b110, giving the gate function code loaded on reset.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have ports A, B, C and D, each input, 1 bit: gate operands.
REQ-006 The block SHALL have port sel, input, 3 bits: gate function code.
REQ-007 The block SHALL have port sel_load, input, 1 bit: when 1, latch sel into the function register.
REQ-008 The block SHALL have port en, input, 1 bit: when 1, update the outputs.
REQ-009 The block SHALL have port F, output, 1 bit: registered gate result.
REQ-010 The block SHALL have port ones, output, 3 bits: registered count of 1s among A..D (0..4).
REQ-011 The block SHALL have port f_chg, output, 1 bit: one-cycle pulse when F changes value.

Function
REQ-012 The block SHALL hold a 3-bit function register func that selects the combinational result g from A..D:
- 000: A&B&C&D
- 001: A|B|C|D
- 010: ~(A&B&C&D)
- 011: ~(A|B|C|D)
- 100: A^B^C^D
- 101: ~(A^B^C^D)
- 110: (A&B)|(C&D)
- 111: majority, i.e. 1 when at least 3 of the 4 inputs are 1.
REQ-013 On each rising edge with rst=0 and sel_load=1, func SHALL load sel; g in that same cycle SHALL use the old func, so a new code first affects F one edge later.
REQ-014 On each rising edge with rst=0 and en=1, the block SHALL update:
- F <= g
- ones <= popcount(A,B,C,D)
- f_chg <= (g != current F).
REQ-015 On each rising edge with rst=0 and en=0, F and ones SHALL hold and f_chg SHALL be 0.
REQ-016 Latency SHALL be one cycle: inputs sampled at edge N appear on F and ones after edge N.
REQ-017 f_chg SHALL be high for exactly one cycle per change of F, and SHALL stay low when en=1 and g equals F.
REQ-018 sel_load and en asserted in the same cycle SHALL both take effect; F SHALL use the pre-load func.
REQ-019 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-020 ones SHALL be unsigned and SHALL never exceed 4.

Reset
REQ-021 On a rising edge with rst=1, the block SHALL set F=RESET_F, ones=0, f_chg=0 and func=DEFAULT_SEL.
REQ-022 rst SHALL take priority over sel_load and en.
REQ-023 Asserting rst mid-operation SHALL discard any pending update in that cycle.
REQ-024 Before the first reset edge, output values are undefined and SHALL NOT be checked.
REQ-025 After rst deasserts, the first edge with en=1 SHALL produce a valid F.

Verification
REQ-026 The bench SHALL cover the default function: after reset, en=1, A=B=C=D=0 -> F=0; then A=1 -> F=0, ones=1, f_chg=0; then B=1 -> F=1, ones=2, with a one-cycle f_chg=1.
REQ-027 The bench SHALL cover function select: sel=100 with sel_load=1 and inputs A=1,B=1,C=1,D=0 -> next edge F still uses function 110 (F=1); following edge F=1 (XOR); then D=1 -> F=0, ones=4, f_chg=1.
REQ-028 The bench SHALL sweep all 8 codes over all 16 input combinations with en=1; F SHALL match the REQ-012 table one cycle later, and ones SHALL match the popcount.
REQ-029 The bench SHALL cover the hold case: en=0 with inputs toggling -> F and ones unchanged, f_chg=0 throughout.
REQ-030 The bench SHALL cover reset priority: rst=1 with sel_load=1, sel=000 and en=1 -> F=RESET_F, ones=0, f_chg=0, func=110 (checked by A=B=1,C=D=0 giving F=1 after reset).
REQ-031 The bench SHALL cover the no-change case: en=1 with constant inputs for 5 cycles -> f_chg stays 0 after the first update.

Source files
------------

// File: rtl/multi_compuerta.sv
// multi_compuerta: selectable four-input gate with registered result,
// registered population count of the operands and a change pulse on F.
// The gate function is held in an internal register loaded from sel.
module multi_compuerta #(
   parameter logic       RESET_F     = 1'b0,
   parameter logic [2:0] DEFAULT_SEL = 3'b110
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   input  logic       D,
   input  logic [2:0] sel,
   input  logic       sel_load,
   input  logic       en,
   output logic       F,
   output logic [2:0] ones,
   output logic       f_chg
);

   // Gate function codes as held in the function register
   typedef enum logic [2:0] {
      FN_AND  = 3'b000,
      FN_OR   = 3'b001,
      FN_NAND = 3'b010,
      FN_NOR  = 3'b011,
      FN_XOR  = 3'b100,
      FN_XNOR = 3'b101,
      FN_AOI  = 3'b110,
      FN_MAJ  = 3'b111
   } func_t;

   func_t      func;
   logic       g;
   logic [2:0] pop;

   // Population count of the four operands, zero-extended to 3 bits
   always_comb begin
      pop = 3'd0;
      pop = {2'b00, A} + {2'b00, B} + {2'b00, C} + {2'b00, D};
   end

   // Gate result selected by the currently held function (old value on a load edge)
   always_comb begin
      g = 1'b0;
      case (func)
         FN_AND:  g = A & B & C & D;
         FN_OR:   g = A | B | C | D;
         FN_NAND: g = ~(A & B & C & D);
         FN_NOR:  g = ~(A | B | C | D);
         FN_XOR:  g = A ^ B ^ C ^ D;
         FN_XNOR: g = ~(A ^ B ^ C ^ D);
         FN_AOI:  g = (A & B) | (C & D);
         FN_MAJ:  g = (pop >= 3'd3);
         default: g = 1'b0;
      endcase
   end

   // Function register: reset to the default code, otherwise load sel on request
   always_ff @(posedge clk) begin
      if (rst) begin
         func <= func_t'(DEFAULT_SEL);
      end else if (sel_load) begin
         func <= func_t'(sel);
      end
   end

   // Output registers: capture gate result and count when enabled, pulse f_chg on change
   always_ff @(posedge clk) begin
      if (rst) begin
         F     <= RESET_F;
         ones  <= 3'd0;
         f_chg <= 1'b0;
      end else if (en) begin
         F     <= g;
         ones  <= pop;
         f_chg <= (g != F);
      end else begin
         f_chg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_compuerta.sv
// Directed self-checking bench for multi_compuerta: reset state, default
// function, function select, full code/input sweep, hold, reset priority
// and steady-input behaviour of the change pulse.
module tb_multi_compuerta;

   logic       clk;
   logic       rst;
   logic       A, B, C, D;
   logic [2:0] sel;
   logic       sel_load;
   logic       en;
   logic       F;
   logic [2:0] ones;
   logic       f_chg;

   int check_count = 0;
   int fail_count  = 0;

   multi_compuerta #(
      .RESET_F    (1'b0),
      .DEFAULT_SEL(3'b110)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .A       (A),
      .B       (B),
      .C       (C),
      .D       (D),
      .sel     (sel),
      .sel_load(sel_load),
      .en      (en),
      .F       (F),
      .ones    (ones),
      .f_chg   (f_chg)
   );

   // Free-running clock, 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive operands and controls, then advance one rising edge and settle
   task automatic apply_stimulus(input logic [3:0] abcd, input logic en_v,
                                 input logic ld_v, input logic [2:0] sel_v,
                                 input logic rst_v);
      {A, B, C, D} = abcd;
      en       = en_v;
      sel_load = ld_v;
      sel      = sel_v;
      rst      = rst_v;
      @(posedge clk);
      #1;
   endtask

   // Compare all three outputs against expected values
   task automatic check_output(input string tag, input logic exp_f,
                               input logic [2:0] exp_ones, input logic exp_chg);
      check_count++;
      assert (F === exp_f) else begin
         fail_count++;
         $error("[TB] FAIL %s.F observed=%b expected=%b", tag, F, exp_f);
      end
      check_count++;
      assert (ones === exp_ones) else begin
         fail_count++;
         $error("[TB] FAIL %s.ones observed=%0d expected=%0d", tag, ones, exp_ones);
      end
      check_count++;
      assert (f_chg === exp_chg) else begin
         fail_count++;
         $error("[TB] FAIL %s.f_chg observed=%b expected=%b", tag, f_chg, exp_chg);
      end
   endtask

   // Reference gate table
   function automatic logic ref_gate(input logic [2:0] code, input logic [3:0] v);
      int cnt;
      cnt = v[3] + v[2] + v[1] + v[0];
      case (code)
         3'b000:  return (v == 4'b1111);
         3'b001:  return (v != 4'b0000);
         3'b010:  return (v != 4'b1111);
         3'b011:  return (v == 4'b0000);
         3'b100:  return (cnt % 2 == 1);
         3'b101:  return (cnt % 2 == 0);
         3'b110:  return (v[3] && v[2]) || (v[1] && v[0]);
         default: return (cnt >= 3);
      endcase
   endfunction

   initial begin
      logic       prev_f;
      logic       exp_f;
      logic [2:0] exp_ones;

      {A, B, C, D} = 4'b0000;
      en = 1'b0; sel_load = 1'b0; sel = 3'b000; rst = 1'b1;
      @(negedge clk);

      // Reset state
      apply_stimulus(4'b0000, 1'b0, 1'b0, 3'b000, 1'b1);
      check_output("reset", 1'b0, 3'd0, 1'b0);

      // Default function (A&B)|(C&D)
      apply_stimulus(4'b0000, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("def_zero", 1'b0, 3'd0, 1'b0);
      apply_stimulus(4'b1000, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("def_a", 1'b0, 3'd1, 1'b0);
      apply_stimulus(4'b1100, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("def_ab", 1'b1, 3'd2, 1'b1);
      apply_stimulus(4'b1100, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("def_ab_hold", 1'b1, 3'd2, 1'b0);

      // Function select: load XOR while enabled, old function applies on that edge
      apply_stimulus(4'b1110, 1'b1, 1'b1, 3'b100, 1'b0);
      check_output("sel_load_edge", 1'b1, 3'd3, 1'b0);
      apply_stimulus(4'b1110, 1'b1, 1'b0, 3'b100, 1'b0);
      check_output("xor_1110", 1'b1, 3'd3, 1'b0);
      apply_stimulus(4'b1111, 1'b1, 1'b0, 3'b100, 1'b0);
      check_output("xor_1111", 1'b0, 3'd4, 1'b1);

      // Sweep every code over every operand combination
      prev_f   = 1'b0;
      exp_ones = 3'd4;
      for (int code = 0; code < 8; code++) begin
         apply_stimulus(4'b0000, 1'b0, 1'b1, 3'(code), 1'b0);
         check_output($sformatf("load_%0d", code), prev_f, exp_ones, 1'b0);
         for (int v = 0; v < 16; v++) begin
            apply_stimulus(4'(v), 1'b1, 1'b0, 3'(code), 1'b0);
            exp_f    = ref_gate(3'(code), 4'(v));
            exp_ones = 3'($countones(4'(v)));
            check_output($sformatf("sweep_%0d_%0d", code, v), exp_f, exp_ones,
                         exp_f != prev_f);
            prev_f = exp_f;
         end
      end

      // Hold: en low with toggling inputs (majority, last inputs 1111 -> F=1, ones=4)
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(4'(i * 5), 1'b0, 1'b0, 3'b000, 1'b0);
         check_output($sformatf("hold_%0d", i), 1'b1, 3'd4, 1'b0);
      end

      // Constant inputs for five enabled cycles: one change, then steady
      apply_stimulus(4'b0000, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("steady_0", 1'b0, 3'd0, 1'b1);
      for (int i = 1; i < 5; i++) begin
         apply_stimulus(4'b0000, 1'b1, 1'b0, 3'b000, 1'b0);
         check_output($sformatf("steady_%0d", i), 1'b0, 3'd0, 1'b0);
      end

      // Reset priority over load and enable; func must come back as 110
      apply_stimulus(4'b1100, 1'b1, 1'b1, 3'b000, 1'b0);
      check_output("pre_rst", 1'b0, 3'd2, 1'b0);
      apply_stimulus(4'b1100, 1'b1, 1'b1, 3'b000, 1'b1);
      check_output("rst_prio", 1'b0, 3'd0, 1'b0);
      apply_stimulus(4'b1100, 1'b1, 1'b0, 3'b000, 1'b0);
      check_output("post_rst_func", 1'b1, 3'd2, 1'b1);

      $display("%0d/%0d checks passed", check_count - fail_count, check_count);
      $finish;
   end

endmodule
